sram_port_arbiter: RTL and testbench

Shares the single-ported SRAM_Controller between several datapath requesters, such as the colourspace-conversion FSM, the VGA fetch unit and the upsampling/IDCT stages. Grants one requester per cycle and registers the winning address, write data and write enable onto the SRAM controller inputs. Tags every read so that returning data is flagged to the issuing requester after the fixed SRAM read latency. Sits between the requester FSMs and SRAM_Controller in the top-level module.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arb_tag_pipe.sv | 45 ++++
 rtl/sram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   SRAM_ADDR_W / SRAM_DATA_W : SRAM_Controller address and data widths
//   ARB_ID_W                  : width of a requester id carried in read tags
//   sram_arb_state_t          : arbiter lock FSM states
//   arb_tag_t                 : {valid, id} tag travelling alongside a read
package sram_arb_pkg;

   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 16;
   localparam int unsigned ARB_ID_W    = 2;

   typedef enum logic {
      S_ARB_IDLE,
      S_ARB_LOCKED
   } sram_arb_state_t;

   typedef struct packed {
      logic                valid;
      logic [ARB_ID_W-1:0] id;
   } arb_tag_t;

endpackage

// File: rtl/sram_arb_tag_pipe.sv
// Read-tag delay line. A tag pushed with a granted read reaches the last
// stage exactly when the SRAM returns that read's data, and is decoded there
// into a one-hot per-requester valid.
//   clk_i    : clock
//   clr_i    : synchronous clear, drops every tag in flight
//   tag_i    : tag pushed this cycle (valid=0 for writes / idle cycles)
//   rvalid_o : one-hot owner of the read data returning this cycle
module sram_arb_tag_pipe
   import sram_arb_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned NUM_REQ      = 3
) (
   input  logic               clk_i,
   input  logic               clr_i,
   input  arb_tag_t           tag_i,
   output logic [NUM_REQ-1:0] rvalid_o
);

   // One extra stage covers the output register between grant and SRAM.
   arb_tag_t pipe_q [READ_LATENCY+1];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int unsigned s = 0; s <= READ_LATENCY; s++) begin
            pipe_q[s] <= '0;
         end
      end else begin
         pipe_q[0] <= tag_i;
         for (int unsigned s = 1; s <= READ_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pipe_q[READ_LATENCY].valid && pipe_q[READ_LATENCY].id == ARB_ID_W'(i)) begin
            rvalid_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates several requesters onto the single-ported SRAM_Controller.
// One grant per cycle; the winner's address/data/we_n are registered onto
// the SRAM inputs, and reads are tagged so returning data is flagged to the
// issuing requester.
//   Clock_50          : system clock
//   Reset             : synchronous active-high reset
//   SRAM_ready_i      : controller ready, no grants while low
//   req_i/lock_i      : per-requester request and burst-lock
//   we_n_i            : per-requester write enable, active-low
//   addr_i/wdata_i    : packed per-requester address and write data
//   gnt_o             : one-hot combinational grant
//   SRAM_address_o    : registered address
//   SRAM_write_data_o : registered write data
//   SRAM_we_n_o       : registered write enable, active-low
//   SRAM_read_data_i  : read data from the controller
//   rdata_o           : read data pass-through
//   rvalid_o          : one-hot owner of rdata_o this cycle
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned LOCK_MAX     = 8
) (
   input  logic                           Clock_50,
   input  logic                           Reset,
   input  logic                           SRAM_ready_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ-1:0]             lock_i,
   input  logic [NUM_REQ-1:0]             we_n_i,
   input  logic [SRAM_ADDR_W*NUM_REQ-1:0] addr_i,
   input  logic [SRAM_DATA_W*NUM_REQ-1:0] wdata_i,
   output logic [NUM_REQ-1:0]             gnt_o,
   output logic [SRAM_ADDR_W-1:0]         SRAM_address_o,
   output logic [SRAM_DATA_W-1:0]         SRAM_write_data_o,
   output logic                           SRAM_we_n_o,
   input  logic [SRAM_DATA_W-1:0]         SRAM_read_data_i,
   output logic [SRAM_DATA_W-1:0]         rdata_o,
   output logic [NUM_REQ-1:0]             rvalid_o
);

   localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

   sram_arb_state_t     state_q, state_d;
   logic [ARB_ID_W-1:0] owner_q, owner_d;
   logic [ARB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ARB_ID_W-1:0] excl_id_q, excl_id_d;
   logic [3:0]          lock_cnt_q, lock_cnt_d;
   logic                excl_q, excl_d;

   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic                   we_n_q, we_n_d;

   logic [NUM_REQ-1:0]  excl_mask, req_m, gnt, pipe_rvalid;
   logic [ARB_ID_W-1:0] grant_id;
   logic                grant_vld, lock_win, own_req, own_lock, lock_sel;
   arb_tag_t            push_tag;

   always_comb begin
      excl_mask = '0;
      own_req   = 1'b0;
      own_lock  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (excl_q && excl_id_q == ARB_ID_W'(i)) excl_mask[i] = 1'b1;
         if (owner_q == ARB_ID_W'(i)) begin
            own_req  = req_i[i];
            own_lock = lock_i[i];
         end
      end

      // An expired owner sits out one arbitration round unless nobody else asks.
      req_m = req_i & ~excl_mask;
      if (req_m == '0) req_m = req_i;

      lock_win = (state_q == S_ARB_LOCKED) && own_req && own_lock &&
                 (lock_cnt_q < LOCK_MAX_C);

      grant_vld = 1'b0;
      grant_id  = '0;
      if (SRAM_ready_i && !Reset) begin
         if (lock_win) begin
            grant_vld = 1'b1;
            grant_id  = owner_q;
         end else if (req_m[0]) begin
            grant_vld = 1'b1;
            grant_id  = '0;
         end else begin
            // Round-robin split into two passes: rr_ptr..top, then 1..rr_ptr-1.
            for (int unsigned i = 1; i < NUM_REQ; i++) begin
               if (!grant_vld && req_m[i] && ARB_ID_W'(i) >= rr_ptr_q) begin
                  grant_vld = 1'b1;
                  grant_id  = ARB_ID_W'(i);
               end
            end
            for (int unsigned i = 1; i < NUM_REQ; i++) begin
               if (!grant_vld && req_m[i] && ARB_ID_W'(i) < rr_ptr_q) begin
                  grant_vld = 1'b1;
                  grant_id  = ARB_ID_W'(i);
               end
            end
         end
      end

      gnt      = '0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_n_d   = 1'b1;
      lock_sel = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_vld && grant_id == ARB_ID_W'(i)) begin
            gnt[i]   = 1'b1;
            addr_d   = addr_i[i*SRAM_ADDR_W +: SRAM_ADDR_W];
            wdata_d  = wdata_i[i*SRAM_DATA_W +: SRAM_DATA_W];
            we_n_d   = we_n_i[i];
            lock_sel = lock_i[i];
         end
      end

      push_tag       = '0;
      push_tag.valid = grant_vld && we_n_d;
      push_tag.id    = grant_id;

      rr_ptr_d = rr_ptr_q;
      if (grant_vld && grant_id != '0) begin
         rr_ptr_d = (grant_id == ARB_ID_W'(NUM_REQ-1)) ? ARB_ID_W'(1)
                                                        : grant_id + ARB_ID_W'(1);
      end

      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      excl_d     = excl_q;
      excl_id_d  = excl_id_q;
      // While the controller is not ready, lock state and count are frozen.
      if (SRAM_ready_i) begin
         excl_d = 1'b0;
         if (lock_win) begin
            state_d    = S_ARB_LOCKED;
            lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
         end else if (grant_vld && lock_sel) begin
            // The grant that opens a burst is the first locked grant.
            state_d    = S_ARB_LOCKED;
            owner_d    = grant_id;
            lock_cnt_d = 4'd1;
         end else begin
            state_d    = S_ARB_IDLE;
            lock_cnt_d = '0;
         end
         if (state_d == S_ARB_LOCKED && lock_cnt_d >= LOCK_MAX_C) begin
            state_d    = S_ARB_IDLE;
            lock_cnt_d = '0;
            excl_d     = 1'b1;
            excl_id_d  = owner_d;
         end
      end
   end

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q    <= S_ARB_IDLE;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         rr_ptr_q   <= ARB_ID_W'(1);
         excl_q     <= 1'b0;
         excl_id_q  <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         excl_q     <= excl_d;
         excl_id_q  <= excl_id_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_n_q     <= we_n_d;
      end
   end

   sram_arb_tag_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .NUM_REQ      (NUM_REQ)
   ) u_tag_pipe (
      .clk_i    (Clock_50),
      .clr_i    (Reset),
      .tag_i    (push_tag),
      .rvalid_o (pipe_rvalid)
   );

   assign gnt_o             = gnt;
   assign SRAM_address_o    = addr_q;
   assign SRAM_write_data_o = wdata_q;
   assign SRAM_we_n_o       = we_n_q;
   assign rdata_o           = SRAM_read_data_i;
   assign rvalid_o          = Reset ? '0 : pipe_rvalid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   logic        Clock_50 = 1'b0;
   logic        Reset;
   logic        SRAM_ready_i;
   logic [2:0]  req_i, lock_i, we_n_i;
   logic [53:0] addr_i;
   logic [47:0] wdata_i;
   logic [2:0]  gnt_o, rvalid_o;
   logic [17:0] SRAM_address_o;
   logic [15:0] SRAM_write_data_o, SRAM_read_data_i, rdata_o;
   logic        SRAM_we_n_o;

   int errors = 0;
   int checks = 0;

   logic [2:0]  rr_exp  [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
   logic [17:0] rr_addr [4] = '{18'd200, 18'd300, 18'd200, 18'd300};

   sram_port_arbiter #(
      .NUM_REQ      (3),
      .READ_LATENCY (2),
      .LOCK_MAX     (8)
   ) dut (
      .Clock_50          (Clock_50),
      .Reset             (Reset),
      .SRAM_ready_i      (SRAM_ready_i),
      .req_i             (req_i),
      .lock_i            (lock_i),
      .we_n_i            (we_n_i),
      .addr_i            (addr_i),
      .wdata_i           (wdata_i),
      .gnt_o             (gnt_o),
      .SRAM_address_o    (SRAM_address_o),
      .SRAM_write_data_o (SRAM_write_data_o),
      .SRAM_we_n_o       (SRAM_we_n_o),
      .SRAM_read_data_i  (SRAM_read_data_i),
      .rdata_o           (rdata_o),
      .rvalid_o          (rvalid_o)
   );

   always #5 Clock_50 = ~Clock_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clock_50);
      #1;
   endtask

   task automatic set_ops(input int r, input logic wn, input logic [17:0] a, input logic [15:0] d);
      we_n_i[r]          = wn;
      addr_i[r*18 +: 18] = a;
      wdata_i[r*16 +: 16] = d;
   endtask

   initial begin
      Reset = 1'b1; SRAM_ready_i = 1'b1;
      req_i = 3'b111; lock_i = '0; we_n_i = '1;
      addr_i = '0; wdata_i = '0; SRAM_read_data_i = '0;

      // Reset state, with requests pending
      tick; tick; #1;
      chk("rst_gnt",    gnt_o, 3'b000);
      chk("rst_we_n",   SRAM_we_n_o, 1'b1);
      chk("rst_addr",   SRAM_address_o, 18'd0);
      chk("rst_wdata",  SRAM_write_data_o, 16'd0);
      chk("rst_rvalid", rvalid_o, 3'b000);
      Reset = 1'b0; req_i = '0;
      tick;

      // Contention: requester 0 first, then round-robin between 1 and 2
      set_ops(0, 1'b1, 18'd100, 16'h0);
      set_ops(1, 1'b1, 18'd200, 16'h0);
      set_ops(2, 1'b1, 18'd300, 16'h0);
      req_i = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1; chk("cont_p0_gnt", gnt_o, 3'b001); tick;
      end
      chk("cont_p0_addr", SRAM_address_o, 18'd100);
      req_i = 3'b110;
      for (int k = 0; k < 4; k++) begin
         #1; chk("cont_rr_gnt", gnt_o, rr_exp[k]);
         tick; chk("cont_rr_addr", SRAM_address_o, rr_addr[k]);
      end
      req_i = '0;
      repeat (4) tick;

      // Single read by requester 1
      set_ops(1, 1'b1, 18'd38400, 16'h0);
      req_i = 3'b010;
      #1; chk("rd_gnt", gnt_o, 3'b010); tick;
      req_i = '0;
      chk("rd_addr", SRAM_address_o, 18'd38400);
      chk("rd_we_n", SRAM_we_n_o, 1'b1);
      #1; chk("rd_gnt_idle", gnt_o, 3'b000); tick;
      chk("rd_rvalid_c2", rvalid_o, 3'b000); tick;
      SRAM_read_data_i = 16'hC0DE;
      #1; chk("rd_rvalid_c3", rvalid_o, 3'b010);
      chk("rd_rdata", rdata_o, 16'hC0DE); tick;
      chk("rd_rvalid_c4", rvalid_o, 3'b000);

      // Write by requester 2
      set_ops(2, 1'b0, 18'd146944, 16'hA55A);
      req_i = 3'b100;
      #1; chk("wr_gnt", gnt_o, 3'b100); tick;
      req_i = '0; set_ops(2, 1'b1, 18'd0, 16'h0);
      chk("wr_we_n_c1",  SRAM_we_n_o, 1'b0);
      chk("wr_wdata_c1", SRAM_write_data_o, 16'hA55A);
      chk("wr_addr_c1",  SRAM_address_o, 18'd146944);
      tick;
      chk("wr_we_n_c2",  SRAM_we_n_o, 1'b1);
      chk("wr_addr_hold", SRAM_address_o, 18'd146944);
      tick;
      chk("wr_rvalid_c3", rvalid_o, 3'b000);
      tick;

      // Lock expiry hands the next round to the other low-priority requester
      req_i = 3'b010; lock_i = 3'b010;
      for (int k = 0; k < 9; k++) begin
         if (k == 1) req_i = 3'b110;
         #1; chk("excl_gnt", gnt_o, (k < 8) ? 3'b010 : 3'b100); tick;
      end
      req_i = '0; lock_i = '0; tick;

      // Expired owner re-granted when it is the only requester
      req_i = 3'b100; lock_i = 3'b100;
      for (int k = 0; k < 9; k++) begin
         #1; chk("sole_gnt", gnt_o, 3'b100); tick;
      end
      req_i = '0; lock_i = '0;
      #1; chk("sole_release", gnt_o, 3'b000); tick;

      // Lock blocks requester 0 for LOCK_MAX grants
      req_i = 3'b010; lock_i = 3'b010;
      for (int k = 0; k < 9; k++) begin
         if (k == 2) req_i = 3'b011;
         #1; chk("lock_gnt", gnt_o, (k < 8) ? 3'b010 : 3'b001); tick;
      end
      req_i = 3'b010;
      #1; chk("lock_resume", gnt_o, 3'b010); tick;
      req_i = '0; lock_i = '0; tick;

      // Ready drops mid-burst: lock count survives the stall
      set_ops(1, 1'b0, 18'd7, 16'h0BEE);
      req_i = 3'b010; lock_i = 3'b010;
      for (int k = 0; k < 11; k++) begin
         SRAM_ready_i = !(k == 3 || k == 4);
         if (k >= 3) req_i = 3'b011;
         #1;
         chk("stall_gnt", gnt_o, (k == 3 || k == 4) ? 3'b000 :
                                 (k == 10) ? 3'b001 : 3'b010);
         tick;
         if (k == 2) begin
            chk("stall_we_n_burst", SRAM_we_n_o, 1'b0);
            chk("stall_wdata", SRAM_write_data_o, 16'h0BEE);
         end
         if (k == 3) begin
            chk("stall_we_n_idle", SRAM_we_n_o, 1'b1);
            chk("stall_addr_hold", SRAM_address_o, 18'd7);
         end
      end
      req_i = '0; lock_i = '0; set_ops(1, 1'b1, 18'd0, 16'h0);

      // Not ready: no grants at all
      SRAM_ready_i = 1'b0; req_i = 3'b111;
      for (int k = 0; k < 3; k++) begin
         #1; chk("nrdy_gnt", gnt_o, 3'b000); tick;
         chk("nrdy_we_n", SRAM_we_n_o, 1'b1);
      end
      SRAM_ready_i = 1'b1; req_i = '0;
      repeat (4) tick;

      // Reset while a read is in flight
      set_ops(0, 1'b1, 18'd5, 16'h0);
      req_i = 3'b001;
      #1; chk("rstrd_gnt", gnt_o, 3'b001); tick;
      Reset = 1'b1; req_i = 3'b111;
      #1; chk("rstrd_gnt_rst", gnt_o, 3'b000);
      chk("rstrd_rvalid_c1", rvalid_o, 3'b000); tick;
      Reset = 1'b0; req_i = '0;
      for (int k = 0; k < 4; k++) begin
         chk("rstrd_rvalid", rvalid_o, 3'b000);
         chk("rstrd_we_n", SRAM_we_n_o, 1'b1);
         chk("rstrd_addr", SRAM_address_o, 18'd0);
         tick;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
